// File: rtl/button_reader_pkg.sv
// Shared types and board timing defaults for the push-button reader.
// FSM encoding is fixed so debug probes can decode the state bits.
package button_reader_pkg;

  localparam int unsigned DEF_DEBOUNCE_CYCLES = 120000;
  localparam int unsigned DEF_LONG_CYCLES     = 12000000;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    PRESS_DB  = 3'd1,
    HELD      = 3'd2,
    LONG_HELD = 3'd3,
    REL_DB    = 3'd4
  } state_t;

endpackage

// File: rtl/button_reader_sync_2ff.sv
// Two-flop synchroniser with a parameterised reset value.
// Shared by every asynchronous board input.
module sync_2ff #(
  parameter int unsigned WIDTH   = 1,
  parameter logic        RST_VAL = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] s1_q;
  logic [WIDTH-1:0] s2_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= {WIDTH{RST_VAL}};
      s2_q <= {WIDTH{RST_VAL}};
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
    end
  end

  assign q_o = s2_q;

endmodule

// File: rtl/button_reader.sv
// Push-button reader: synchronise, debounce, classify short/long press.
// Emits a debounced level, one-cycle pulses and a wrapping press count.
module button_reader
  import button_reader_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned LONG_CYCLES     = DEF_LONG_CYCLES,
  parameter bit          ACTIVE_LOW      = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_in,
  output logic       pressed,
  output logic       short_pulse,
  output logic       long_pulse,
  output logic [7:0] press_count
);

  localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HOLD_W = $clog2(LONG_CYCLES + 1);

  // The IDLE/HELD sample that enters a debounce state counts as the
  // first stable cycle, so the debounce window ends one count early.
  localparam logic [DB_W-1:0]   DB_END   = DB_W'(DEBOUNCE_CYCLES - 2);
  localparam logic [HOLD_W-1:0] HOLD_END = HOLD_W'(LONG_CYCLES - 1);

  logic btn_s;
  logic act;

  state_t            state_q, state_d;
  logic [DB_W-1:0]   db_q, db_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              lflag_q, lflag_d;
  logic              pressed_q, pressed_d;
  logic              short_q, short_d;
  logic              long_q, long_d;
  logic [7:0]        cnt_q, cnt_d;

  sync_2ff #(
    .WIDTH   (1),
    .RST_VAL (ACTIVE_LOW)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (btn_in),
    .q_o   (btn_s)
  );

  assign act = btn_s ^ ACTIVE_LOW;

  always_comb begin
    state_d   = state_q;
    db_d      = db_q;
    hold_d    = hold_q;
    lflag_d   = lflag_q;
    pressed_d = pressed_q;
    cnt_d     = cnt_q;
    short_d   = 1'b0;
    long_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (act) begin
          state_d = PRESS_DB;
          db_d    = '0;
        end
      end
      PRESS_DB: begin
        if (!act) begin
          state_d = IDLE;
        end else if (db_q == DB_END) begin
          state_d   = HELD;
          pressed_d = 1'b1;
          cnt_d     = cnt_q + 8'd1;
          hold_d    = '0;
          lflag_d   = 1'b0;
        end else begin
          db_d = db_q + 1'b1;
        end
      end
      HELD: begin
        // Reaching the long threshold wins over a same-cycle release.
        if (hold_q == HOLD_END) begin
          long_d  = 1'b1;
          lflag_d = 1'b1;
          db_d    = '0;
          state_d = act ? LONG_HELD : REL_DB;
        end else if (!act) begin
          state_d = REL_DB;
          lflag_d = 1'b0;
          db_d    = '0;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      LONG_HELD: begin
        if (!act) begin
          state_d = REL_DB;
          lflag_d = 1'b1;
          db_d    = '0;
        end
      end
      REL_DB: begin
        if (act) begin
          state_d = lflag_q ? LONG_HELD : HELD;
        end else if (db_q == DB_END) begin
          state_d   = IDLE;
          pressed_d = 1'b0;
          short_d   = ~lflag_q;
        end else begin
          db_d = db_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      db_q      <= '0;
      hold_q    <= '0;
      lflag_q   <= 1'b0;
      pressed_q <= 1'b0;
      short_q   <= 1'b0;
      long_q    <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      db_q      <= db_d;
      hold_q    <= hold_d;
      lflag_q   <= lflag_d;
      pressed_q <= pressed_d;
      short_q   <= short_d;
      long_q    <= long_d;
      cnt_q     <= cnt_d;
    end
  end

  assign pressed     = pressed_q;
  assign short_pulse = short_q;
  assign long_pulse  = long_q;
  assign press_count = cnt_q;

endmodule

// File: tb/tb_button_reader.sv
// Self-checking bench for button_reader against a run-length model.
// Small timing parameters keep every scenario short.
module tb_button_reader;

  localparam int D = 4;
  localparam int L = 20;

  logic       clk;
  logic       rst_n;
  logic       btn_in;
  logic       pressed;
  logic       short_pulse;
  logic       long_pulse;
  logic [7:0] press_count;

  button_reader #(
    .DEBOUNCE_CYCLES (D),
    .LONG_CYCLES     (L),
    .ACTIVE_LOW      (1'b1)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .btn_in      (btn_in),
    .pressed     (pressed),
    .short_pulse (short_pulse),
    .long_pulse  (long_pulse),
    .press_count (press_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int errs    = 0;
  int shorts  = 0;

  // Reference model: pin delay line plus stable-run counters.
  bit m1, m2;
  bit pm, lm, sp_m, lp_m;
  int run, rrun, ht, cnt_m;
  bit in_rst;

  task automatic model_reset();
    m1 = 1'b1; m2 = 1'b1;
    pm = 0; lm = 0; sp_m = 0; lp_m = 0;
    run = 0; rrun = 0; ht = 0; cnt_m = 0;
  endtask

  task automatic model_step(input bit b);
    bit a;
    a  = ~m2;
    m2 = m1;
    m1 = b;
    sp_m = 0;
    lp_m = 0;
    if (!pm) begin
      run = a ? run + 1 : 0;
      if (run == D) begin
        pm = 1; lm = 0; ht = 0; run = 0; rrun = 0;
        cnt_m = (cnt_m + 1) % 256;
      end
    end else if (rrun == 0) begin
      if (!lm && ht == L - 1) begin
        lp_m = 1;
        lm   = 1;
      end else if (a && !lm) begin
        ht++;
      end
      if (!a) rrun = 1;
    end else if (a) begin
      rrun = 0;
    end else begin
      rrun++;
      if (rrun == D) begin
        pm = 0; sp_m = ~lm; rrun = 0;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [7:0] got,
                     input logic [7:0] exp);
    vectors++;
    assert (got === exp) else begin
      errs++;
      $error("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic chk_all();
    chk("pressed", {7'd0, pressed}, {7'd0, pm});
    chk("short", {7'd0, short_pulse}, {7'd0, sp_m});
    chk("long", {7'd0, long_pulse}, {7'd0, lp_m});
    chk("count", press_count, 8'(cnt_m));
  endtask

  task automatic step(input bit b);
    btn_in = b;
    @(posedge clk);
    if (!in_rst) model_step(b);
    @(negedge clk);
    if (short_pulse === 1'b1) shorts++;
    chk_all();
  endtask

  task automatic hold(input bit b, input int n);
    for (int i = 0; i < n; i++) step(b);
  endtask

  // Asserts reset mid-cycle, checks outputs clear without a clock.
  task automatic reset_pulse(input int cyc, input bit toggle);
    #2 rst_n = 1'b0;
    in_rst = 1;
    model_reset();
    #1 chk_all();
    @(negedge clk);
    for (int i = 0; i < cyc; i++)
      step(toggle ? bit'($urandom_range(0, 1)) : btn_in);
    rst_n  = 1'b1;
    in_rst = 0;
  endtask

  initial begin
    rst_n  = 1'b0;
    btn_in = 1'b1;
    in_rst = 1;
    model_reset();
    @(negedge clk);

    // 1: reset with toggling pin, then idle high
    reset_pulse(8, 1'b1);
    btn_in = 1'b1;
    hold(1, 50);

    // 2: clean short press; pressed must be up 6 edges after the edge
    hold(0, 5);
    chk("pre_latency", {7'd0, pressed}, 8'd0);
    step(0);
    chk("latency6", {7'd0, pressed}, 8'd1);
    hold(0, 4);
    hold(1, 12);
    chk("cnt_after_short", press_count, 8'd1);
    chk("one_short", 8'(shorts), 8'd1);

    // 3: press bounces, then release bounces during hold
    for (int k = 0; k < 5; k++) begin
      hold(0, 3);
      hold(1, 2);
    end
    hold(1, 6);
    chk("bounce_cnt", press_count, 8'd1);
    hold(0, 10);
    for (int k = 0; k < 3; k++) begin
      hold(1, 3);
      hold(0, 3);
    end
    hold(1, 12);

    // 4: long press
    hold(0, 40);
    hold(1, 12);

    // simultaneous release on the long threshold edge
    hold(0, 6 + L - 3);
    hold(1, 14);

    // random segments
    for (int k = 0; k < 80; k++)
      hold(bit'(k % 2), $urandom_range(1, 32));
    hold(1, 12);

    // 5: wrap after 256 short presses
    reset_pulse(2, 1'b0);
    shorts = 0;
    for (int k = 0; k < 256; k++) begin
      hold(0, 8);
      hold(1, 8);
    end
    chk("wrap_cnt", press_count, 8'd0);
    chk("wrap_shorts_lo", 8'(shorts), 8'd0);
    chk("wrap_shorts_hi", 8'(shorts >> 8), 8'd1);

    // 6: reset while held, button still held at release
    btn_in = 1'b0;
    hold(0, 12);
    chk("held_before_rst", {7'd0, pressed}, 8'd1);
    reset_pulse(3, 1'b0);
    hold(0, 5);
    chk("rearm_pre", {7'd0, pressed}, 8'd0);
    step(0);
    chk("rearm_pressed", {7'd0, pressed}, 8'd1);
    chk("rearm_cnt", press_count, 8'd1);
    hold(1, 12);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
